// File: rtl/console_detect_v2.sv
// Power-on console classifier: grounds CIRAM /CE and /A13 for a fixed window,
// then votes on PPU /A13 behaviour to tell an original console from a new famiclone.
module console_detect_v2 #(
   parameter int INIT_CYCLES    = 15,
   parameter int SAMPLES_LO     = 2,
   parameter int SAMPLES_HI     = 2,
   parameter int MISMATCH_MIN   = 1,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 16
) (
   input  logic       m2,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       ppu_rd_stb,
   input  logic       ppu_a13,
   input  logic       ppu_not_a13,
   output logic       ground_en,
   output logic       init_done,
   output logic       detect_valid,
   output logic       new_dendy,
   output logic [3:0] mismatch_cnt,
   output logic       timed_out
);

   localparam int LO_W = $clog2(SAMPLES_LO + 1);
   localparam int HI_W = $clog2(SAMPLES_HI + 1);

   localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [LO_W-1:0]  LO_FULL  = LO_W'(SAMPLES_LO);
   localparam logic [HI_W-1:0]  HI_FULL  = HI_W'(SAMPLES_HI);
   localparam logic [3:0]       MIS_MIN  = 4'(MISMATCH_MIN);

   typedef enum logic [1:0] {
      GROUND,
      LISTEN,
      DECIDE,
      LOCKED
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [LO_W-1:0]  lo_cnt, lo_nxt;
   logic [HI_W-1:0]  hi_cnt, hi_nxt;
   logic [3:0]       mis, mis_nxt;
   logic             tmo, tmo_nxt;
   logic             decision, decision_nxt;
   logic [1:0]       mode_q;
   logic             qual;

   always_ff @(posedge m2) begin
      if (reset) begin
         state    <= GROUND;
         cnt      <= INIT_VAL;
         lo_cnt   <= '0;
         hi_cnt   <= '0;
         mis      <= '0;
         tmo      <= 1'b0;
         decision <= 1'b0;
         mode_q   <= 2'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         lo_cnt   <= lo_nxt;
         hi_cnt   <= hi_nxt;
         mis      <= mis_nxt;
         tmo      <= tmo_nxt;
         decision <= decision_nxt;
         mode_q   <= mode;
      end
   end

   // One counter serves as the grounding down-counter and the listen timeout.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      lo_nxt       = lo_cnt;
      hi_nxt       = hi_cnt;
      mis_nxt      = mis;
      tmo_nxt      = tmo;
      decision_nxt = decision;
      qual         = 1'b0;
      case (state)
         GROUND: begin
            if (cnt <= CNT_ONE) begin
               state_nxt = LISTEN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         LISTEN: begin
            cnt_nxt = cnt + 1'b1;
            if (ppu_rd_stb) begin
               if (!ppu_a13 && lo_cnt < LO_FULL) begin
                  lo_nxt = lo_cnt + 1'b1;
                  qual   = 1'b1;
               end else if (ppu_a13 && hi_cnt < HI_FULL) begin
                  hi_nxt = hi_cnt + 1'b1;
                  qual   = 1'b1;
               end
            end
            // A genuine console drives /A13 as the inverse of A13.
            if (qual && (ppu_a13 == ppu_not_a13) && (mis != 4'hF))
               mis_nxt = mis + 1'b1;
            if (lo_nxt == LO_FULL && hi_nxt == HI_FULL) begin
               state_nxt = DECIDE;
            end else if (cnt == TMO_LAST) begin
               state_nxt = DECIDE;
               tmo_nxt   = 1'b1;
            end
         end
         DECIDE: begin
            decision_nxt = (mis >= MIS_MIN) && !tmo;
            state_nxt    = LOCKED;
         end
         default: ;
      endcase
   end

   // Overrides only mask the outputs; the locked decision survives them.
   always_comb begin
      ground_en    = (state == GROUND);
      init_done    = (state != GROUND);
      detect_valid = (state == LOCKED);
      new_dendy    = (state == LOCKED) && decision;
      mismatch_cnt = mis;
      timed_out    = tmo;
      if (state != GROUND) begin
         case (mode_q)
            2'd1: new_dendy = 1'b0;
            2'd2: begin
               new_dendy    = 1'b1;
               detect_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_console_detect_v2.sv
// Directed bench for console_detect_v2: default instance plus a MISMATCH_MIN=3 instance on shared stimulus.
module tb_console_detect_v2;

   logic       m2 = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       stb = 1'b0, a13 = 1'b0, na13 = 1'b0;

   logic       a_ground, a_init, a_valid, a_new, a_tmo;
   logic [3:0] a_mis;
   logic       b_ground, b_init, b_valid, b_new, b_tmo;
   logic [3:0] b_mis;

   int checks = 0;
   int errors = 0;

   console_detect_v2 dut_a (
      .m2(m2), .reset(reset), .mode(mode), .ppu_rd_stb(stb), .ppu_a13(a13),
      .ppu_not_a13(na13), .ground_en(a_ground), .init_done(a_init),
      .detect_valid(a_valid), .new_dendy(a_new), .mismatch_cnt(a_mis), .timed_out(a_tmo)
   );

   console_detect_v2 #(.MISMATCH_MIN(3)) dut_b (
      .m2(m2), .reset(reset), .mode(mode), .ppu_rd_stb(stb), .ppu_a13(a13),
      .ppu_not_a13(na13), .ground_en(b_ground), .init_done(b_init),
      .detect_valid(b_valid), .new_dendy(b_new), .mismatch_cnt(b_mis), .timed_out(b_tmo)
   );

   always #5 m2 = ~m2;

   task automatic tick();
      @(posedge m2);
      #1;
   endtask

   task automatic strobe(input logic a, input logic n);
      stb  = 1'b1;
      a13  = a;
      na13 = n;
      tick();
      stb  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset values and grounding window
      do_reset();
      chk("rst_ground", a_ground, 1);
      chk("rst_init", a_init, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_new", a_new, 0);
      chk("rst_mis", a_mis, 0);
      chk("rst_tmo", a_tmo, 0);
      chk("rst_ground_b", b_ground, 1);
      repeat (14) tick();
      chk("ground_last", a_ground, 1);
      tick();
      chk("ground_end", a_ground, 0);
      chk("init_done", a_init, 1);

      // original console
      strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(1, 0);
      chk("orig_decide_valid", a_valid, 0);
      chk("orig_mis", a_mis, 0);
      tick();
      chk("orig_valid", a_valid, 1);
      chk("orig_new", a_new, 0);
      strobe(0, 0);
      chk("locked_ignores_stb", a_mis, 0);
      mode = 2'd2; tick();
      chk("lock_force_new", a_new, 1);
      chk("lock_force_valid", a_valid, 1);
      mode = 2'd0; tick();
      chk("lock_restore_new", a_new, 0);
      chk("lock_restore_valid", a_valid, 1);

      // new famiclone
      do_reset();
      repeat (15) tick();
      strobe(0, 0); strobe(1, 1); strobe(0, 0); strobe(1, 1);
      tick();
      chk("fc_new", a_new, 1);
      chk("fc_mis", a_mis, 4);
      chk("fc_new_b", b_new, 1);
      mode = 2'd1; tick();
      chk("fc_force_orig", a_new, 0);
      mode = 2'd0; tick();
      chk("fc_restore", a_new, 1);

      // reset dominates in LOCKED, even with override requested
      reset = 1'b1; mode = 2'd2; tick();
      chk("lockrst_valid", a_valid, 0);
      chk("lockrst_new", a_new, 0);
      chk("lockrst_ground", a_ground, 1);
      chk("lockrst_mis", a_mis, 0);
      reset = 1'b0; mode = 2'd0;

      // single mismatch: default votes famiclone, MISMATCH_MIN=3 votes original
      repeat (15) tick();
      strobe(0, 0); strobe(1, 0); strobe(0, 1); strobe(1, 0);
      tick();
      chk("one_mis_new_a", a_new, 1);
      chk("one_mis_new_b", b_new, 0);
      chk("one_mis_cnt_b", b_mis, 1);
      chk("one_mis_valid_b", b_valid, 1);

      // bucket overflow
      do_reset();
      repeat (15) tick();
      repeat (5) strobe(0, 0);
      chk("ovf_mis", a_mis, 2);
      chk("ovf_valid0", a_valid, 0);
      strobe(1, 0);
      chk("ovf_valid1", a_valid, 0);
      strobe(1, 0);
      chk("ovf_decide", a_valid, 0);
      tick();
      chk("ovf_valid", a_valid, 1);
      chk("ovf_mis_final", a_mis, 2);
      chk("ovf_new_a", a_new, 1);
      chk("ovf_new_b", b_new, 0);

      // override during LISTEN
      do_reset();
      repeat (15) tick();
      mode = 2'd2;
      chk("ovr_pre_valid", a_valid, 0);
      tick();
      chk("ovr_valid", a_valid, 1);
      chk("ovr_new", a_new, 1);
      mode = 2'd1; tick();
      chk("ovr1_valid", a_valid, 0);
      chk("ovr1_new", a_new, 0);
      mode = 2'd0; tick();
      chk("ovr0_valid", a_valid, 0);
      strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(1, 0);
      tick();
      chk("ovr_resume_valid", a_valid, 1);
      chk("ovr_resume_new", a_new, 0);

      // strobe on the GROUND->LISTEN edge is ignored
      do_reset();
      repeat (14) tick();
      strobe(0, 0);
      chk("edge_init", a_init, 1);
      chk("edge_mis", a_mis, 0);

      // reset mid-LISTEN after 3 strobes
      strobe(0, 0); strobe(1, 1); strobe(0, 0);
      chk("mid_mis", a_mis, 3);
      do_reset();
      chk("mid_rst_mis", a_mis, 0);
      chk("mid_rst_ground", a_ground, 1);
      chk("mid_rst_init", a_init, 0);
      repeat (14) tick();
      chk("mid_ground_last", a_ground, 1);
      tick();
      chk("mid_ground_end", a_ground, 0);
      strobe(1, 1);
      tick();
      chk("mid_counts_cleared", a_valid, 0);
      chk("mid_mis_after", a_mis, 1);

      // timeout with no traffic
      do_reset();
      repeat (15) tick();
      repeat (65534) tick();
      chk("tmo_pre", a_tmo, 0);
      chk("tmo_pre_init", a_init, 1);
      tick();
      chk("tmo_set", a_tmo, 1);
      chk("tmo_decide_valid", a_valid, 0);
      tick();
      chk("tmo_valid", a_valid, 1);
      chk("tmo_new", a_new, 0);
      chk("tmo_set_b", b_tmo, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/console_detect_v2.md
Name: console_detect_v2

Overview:
- Power-on console classifier for the cartridge top level, parametrised successor to the single-shot famiclone detection.
- Holds the CIRAM /CE and /A13 grounding window for a configurable number of M2 cycles, then samples qualified PPU reads.
- Classifies the console as original or new-famiclone by a mismatch vote instead of a single hit; adds a timeout, a forced-mode override and a status count.
- Outputs drive ppu_ciram_ce / ppu_not_a13_out tristate selection in the top level.

Parameters:
INIT_CYCLES, 15, M2 cycles the grounding window lasts after reset (1..2^CNT_W-1)
SAMPLES_LO, 2, qualified reads with A13=0 required before decision (>=1)
SAMPLES_HI, 2, qualified reads with A13=1 required before decision (>=1)
MISMATCH_MIN, 1, mismatches needed to classify as new-famiclone (1..SAMPLES_LO+SAMPLES_HI)
TIMEOUT_CYCLES, 65535, M2 cycles in LISTEN before a forced decision of "original"
CNT_W, 16, width of the cycle/timeout counter

Ports:
m2  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high
mode  input  2  0=auto, 1=force original, 2=force new-famiclone, 3=auto (reserved, same as 0)
ppu_rd_stb  input  1  one-cycle pulse per PPU read, already synchronised to m2
ppu_a13  input  1  PPU A13 captured with the strobe
ppu_not_a13  input  1  console /A13 pin captured with the strobe
ground_en  output  1  1 = ground CIRAM /CE and /A13 (power-on window)
init_done  output  1  grounding window finished
detect_valid  output  1  classification locked
new_dendy  output  1  1 = new-famiclone detected/forced
mismatch_cnt  output  4  saturating count of mismatching qualified reads
timed_out  output  1  decision was forced by timeout

Behaviour:
- Reset (sync, active-high): state=GROUND; cycle counter=INIT_CYCLES; sample/mismatch counters=0. Outputs: ground_en=1, init_done=0, detect_valid=0, new_dendy=0, mismatch_cnt=0, timed_out=0. Reset dominates every other input in the same cycle, including mid-LISTEN and LOCKED.
- GROUND: counter decrements once per m2. When the counter reaches 0, the next cycle enters LISTEN. ground_en=1 for exactly INIT_CYCLES cycles after reset deasserts. Strobes in GROUND are ignored.
- LISTEN: ground_en=0, init_done=1. Timeout counter starts at 0 and increments per cycle.
- A strobe is qualified when ppu_a13=0 and lo_cnt<SAMPLES_LO, or ppu_a13=1 and hi_cnt<SAMPLES_HI. A qualified strobe increments the matching counter.
- A qualified strobe with ppu_a13 == ppu_not_a13 (pin not the inverse of A13) increments mismatch_cnt, saturating at 15.
- Non-qualified strobes (bucket already full) change no state.
- Exit to DECIDE: the cycle after lo_cnt==SAMPLES_LO and hi_cnt==SAMPLES_HI.
- Exit to DECIDE on timeout: timeout counter reaches TIMEOUT_CYCLES-1 with buckets incomplete; set timed_out=1.
- DECIDE (1 cycle): new_dendy = (mismatch_cnt >= MISMATCH_MIN) && !timed_out. Next state is LOCKED.
- LOCKED: detect_valid=1. All outputs are held until reset; strobes are ignored.
- Mode override: mode is sampled every cycle.
  - mode=1 forces new_dendy=0; mode=2 forces new_dendy=1 in any state from LISTEN onward, and detect_valid=1 immediately in LISTEN. Internal counting continues.
  - Returning to auto: before LOCKED, resumes normal flow; after LOCKED, restores the locked decision.
  - mode never affects GROUND timing.
- Strobe in the same cycle as the GROUND->LISTEN transition: ignored. Strobe in the cycle the last bucket fills: counted, then transition.
- Latency: decision visible on new_dendy/detect_valid 2 cycles after the final qualifying strobe.

Test Plan:
- Reset, no strobes, defaults -> ground_en=1 for 15 cycles, then init_done=1. After 65535 LISTEN cycles: timed_out=1, detect_valid=1, new_dendy=0.
- Original console: strobes (a13,nota13) = (0,1),(1,0),(0,1),(1,0) -> mismatch_cnt=0, new_dendy=0, detect_valid=1 two cycles after the 4th strobe.
- New famiclone: strobes (0,0),(1,1),(0,0),(1,1) -> mismatch_cnt=4, new_dendy=1. With MISMATCH_MIN=3 and only one mismatch, new_dendy=0.
- Bucket overflow: five A13=0 mismatching strobes then two matching A13=1 strobes -> only 2 lo strobes counted, mismatch_cnt=2, decision after the 2nd hi strobe.
- Override: mode=2 during LISTEN -> new_dendy=1, detect_valid=1 next cycle. Original-console traffic locks new_dendy=0; then mode=2 -> 1, mode=0 -> back to 0.
- Reset asserted mid-LISTEN after 3 strobes -> all counters and outputs return to reset values; ground_en=1 again for 15 cycles.
